wb_pipe_reg: RTL and testbench



---
 rtl/wb_pipe_reg_pkg.sv | 23 ++
 rtl/wb_skid_entry.sv | 33 +++
 rtl/wb_pipe_reg.sv | 125 ++++++++++++
 tb/tb_wb_pipe_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_reg_pkg.sv
// Shared widths and writeback payload layout for the MEM/WB pipeline register.
package wb_pipe_reg_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned RADDR_WIDTH    = 5;
    localparam int unsigned CSR_ADDR_WIDTH = 12;
    localparam int unsigned ZERO_REG       = 0;

    typedef struct packed {
        logic                      reg_we;
        logic [RADDR_WIDTH-1:0]    reg_waddr;
        logic [DATA_WIDTH-1:0]     reg_wdata;
        logic                      csr_we;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        logic [DATA_WIDTH-1:0]     csr_wdata;
    } wb_payload_t;

    // Flattened payload width for non-default parameterisations.
    function automatic int unsigned payload_width(int unsigned dw, int unsigned rw, int unsigned cw);
        return 2 + 2 * dw + rw + cw;
    endfunction

endpackage

// File: rtl/wb_skid_entry.sv
// One pipeline entry: payload plus valid bit, with load and clear (clear wins).
module wb_skid_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear only drops the valid bit; the payload stays visible on the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: output entry plus optional skid entry, gated writes,
// interrupt flush and a per-retire pulse with a wrapping retire counter.
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = wb_pipe_reg_pkg::DATA_WIDTH,
    parameter int unsigned RADDR_WIDTH    = wb_pipe_reg_pkg::RADDR_WIDTH,
    parameter int unsigned CSR_ADDR_WIDTH = wb_pipe_reg_pkg::CSR_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH      = 64,
    parameter bit          SKID_EN        = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      reg_we_i,
    input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    input  logic                      wb_stall_i,
    input  logic                      flush_int_i,
    output logic                      reg_we_o,
    output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
    output logic [DATA_WIDTH-1:0]     reg_wdata_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      instret_incr_o,
    output logic [CNT_WIDTH-1:0]      retired_cnt_o
);

    localparam int unsigned PW = payload_width(DATA_WIDTH, RADDR_WIDTH, CSR_ADDR_WIDTH);

    logic [PW-1:0] in_pl, o_d, o_q, s_q;
    logic          o_valid, s_valid;
    logic          o_load, o_clear, s_load, s_clear;
    logic          accept, commit, o_reg_we, o_csr_we;

    assign in_pl = {reg_we_i, reg_waddr_i, reg_wdata_i, csr_we_i, csr_waddr_i, csr_wdata_i};
    assign {o_reg_we, reg_waddr_o, reg_wdata_o, o_csr_we, csr_waddr_o, csr_wdata_o} = o_q;

    assign accept = in_valid_i & in_ready_o;
    assign commit = o_valid & ~wb_stall_i;

    always_comb begin
        o_load  = 1'b0;
        o_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        o_d     = in_pl;
        if (flush_int_i) begin
            o_clear = 1'b1;
            s_clear = 1'b1;
        end else if (commit) begin
            if (s_valid) begin
                o_load = 1'b1;
                o_d    = s_q;
            end else if (accept) begin
                o_load = 1'b1;
            end else begin
                o_clear = 1'b1;
            end
            if (s_valid && accept) s_load = 1'b1;
            else                   s_clear = 1'b1;
        end else if (accept) begin
            if (!o_valid) o_load = 1'b1;
            else          s_load = 1'b1;
        end
    end

    wb_skid_entry #(.W(PW)) u_entry_o (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (o_load),
        .clear_i (o_clear),
        .d_i     (o_d),
        .valid_o (o_valid),
        .q_o     (o_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            wb_skid_entry #(.W(PW)) u_entry_s (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .load_i  (s_load),
                .clear_i (s_clear),
                .d_i     (in_pl),
                .valid_o (s_valid),
                .q_o     (s_q)
            );
            // Ready comes straight from the skid valid register.
            assign in_ready_o = ~s_valid;
        end else begin : g_noskid
            assign s_valid    = 1'b0;
            assign s_q        = '0;
            assign in_ready_o = ~o_valid | ~wb_stall_i;
        end
    endgenerate

    assign reg_we_o = commit & o_reg_we & (reg_waddr_o != RADDR_WIDTH'(ZERO_REG));
    assign csr_we_o = commit & o_csr_we;

    logic                 instret_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // A commit in a flush cycle still retires; only reset clears the counter.
    assign cnt_d = cnt_q + CNT_WIDTH'(commit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            instret_q <= commit;
            cnt_q     <= cnt_d;
        end
    end

    assign instret_incr_o = instret_q;
    assign retired_cnt_o  = cnt_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg (skid mode, 4-bit retire counter to exercise wrap).
module tb_wb_pipe_reg;

    logic        clk_i = 1'b0;
    logic        rst_i, in_valid_i, in_ready_o;
    logic        reg_we_i, csr_we_i, wb_stall_i, flush_int_i;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic [31:0] reg_wdata_i, reg_wdata_o, csr_wdata_i, csr_wdata_o;
    logic [11:0] csr_waddr_i, csr_waddr_o;
    logic        reg_we_o, csr_we_o, instret_incr_o;
    logic [3:0]  retired_cnt_o;

    int checks = 0;
    int errors = 0;

    wb_pipe_reg #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .CSR_ADDR_WIDTH(12),
                  .CNT_WIDTH(4), .SKID_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .wb_stall_i(wb_stall_i), .flush_int_i(flush_int_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .instret_incr_o(instret_incr_o), .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic put_reg(input logic v, input logic [4:0] a, input logic [31:0] d);
        in_valid_i = v; reg_we_i = v; reg_waddr_i = a; reg_wdata_i = d;
        csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; wb_stall_i = 1'b0; flush_int_i = 1'b0;
        put_reg(1'b0, 5'd0, 32'd0);
        cyc(); cyc(); cyc(); #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready_o); end
        checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rst_reg_we got %b want 0", reg_we_o); end
        checks++; if (csr_we_o !== 1'b0) begin errors++; $display("FAIL rst_csr_we got %b want 0", csr_we_o); end
        checks++; if (instret_incr_o !== 1'b0) begin errors++; $display("FAIL rst_instret got %b want 0", instret_incr_o); end
        checks++; if (retired_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", retired_cnt_o); end
        checks++; if (reg_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", reg_wdata_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_a [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [3:0]  exp_c [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        cyc(); put_reg(1'b1, 5'd1, 32'h11); #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready_o); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i < 3) put_reg(1'b1, exp_a[i+1], exp_d[i+1]); else put_reg(1'b0, 5'd0, 32'd0);
            #1;
            checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== exp_a[i] || reg_wdata_o !== exp_d[i]) begin
                errors++; $display("FAIL b2b_write%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                                   i, reg_we_o, reg_waddr_o, reg_wdata_o, exp_a[i], exp_d[i]); end
            checks++; if (retired_cnt_o !== exp_c[i] || instret_incr_o !== (i > 0)) begin
                errors++; $display("FAIL b2b_cnt%0d got cnt=%0d pulse=%b want cnt=%0d pulse=%b",
                                   i, retired_cnt_o, instret_incr_o, exp_c[i], (i > 0)); end
        end
        cyc(); #1;
        checks++; if (reg_we_o !== 1'b0 || instret_incr_o !== 1'b1 || retired_cnt_o !== 4'd4) begin
            errors++; $display("FAIL b2b_end got we=%b pulse=%b cnt=%0d want we=0 pulse=1 cnt=4",
                               reg_we_o, instret_incr_o, retired_cnt_o); end
        cyc(); #1;
        checks++; if (instret_incr_o !== 1'b0 || retired_cnt_o !== 4'd4) begin
            errors++; $display("FAIL b2b_idle got pulse=%b cnt=%0d want pulse=0 cnt=4", instret_incr_o, retired_cnt_o); end
    endtask

    task automatic test_x0();
        cyc(); put_reg(1'b1, 5'd0, 32'h55);
        cyc(); put_reg(1'b0, 5'd0, 32'd0); #1;
        checks++; if (reg_we_o !== 1'b0 || reg_wdata_o !== 32'h55) begin
            errors++; $display("FAIL x0_write got we=%b d=%h want we=0 d=00000055", reg_we_o, reg_wdata_o); end
        cyc(); #1;
        checks++; if (instret_incr_o !== 1'b1 || retired_cnt_o !== 4'd5) begin
            errors++; $display("FAIL x0_retire got pulse=%b cnt=%0d want pulse=1 cnt=5", instret_incr_o, retired_cnt_o); end
    endtask

    task automatic test_stall();
        cyc(); put_reg(1'b1, 5'd5, 32'hA5); wb_stall_i = 1'b0;
        cyc(); put_reg(1'b1, 5'd6, 32'hB6); wb_stall_i = 1'b1; #1;
        checks++; if (in_ready_o !== 1'b1 || reg_we_o !== 1'b0) begin
            errors++; $display("FAIL stall_c2 got ready=%b we=%b want ready=1 we=0", in_ready_o, reg_we_o); end
        cyc(); put_reg(1'b1, 5'd7, 32'hC7); #1;
        checks++; if (in_ready_o !== 1'b0 || reg_we_o !== 1'b0 || reg_waddr_o !== 5'd5) begin
            errors++; $display("FAIL stall_full got ready=%b we=%b a=%0d want ready=0 we=0 a=5",
                               in_ready_o, reg_we_o, reg_waddr_o); end
        cyc(); #1;
        checks++; if (in_ready_o !== 1'b0 || reg_we_o !== 1'b0) begin
            errors++; $display("FAIL stall_hold got ready=%b we=%b want ready=0 we=0", in_ready_o, reg_we_o); end
        cyc(); wb_stall_i = 1'b0; #1;
        checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'hA5 || in_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_relA got we=%b a=%0d d=%h ready=%b want we=1 a=5 d=a5 ready=0",
                               reg_we_o, reg_waddr_o, reg_wdata_o, in_ready_o); end
        cyc(); #1;
        checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd6 || reg_wdata_o !== 32'hB6 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL stall_relB got we=%b a=%0d d=%h ready=%b want we=1 a=6 d=b6 ready=1",
                               reg_we_o, reg_waddr_o, reg_wdata_o, in_ready_o); end
        cyc(); put_reg(1'b0, 5'd0, 32'd0); #1;
        checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd7 || reg_wdata_o !== 32'hC7) begin
            errors++; $display("FAIL stall_C got we=%b a=%0d d=%h want we=1 a=7 d=c7", reg_we_o, reg_waddr_o, reg_wdata_o); end
        cyc(); cyc(); #1;
        checks++; if (reg_we_o !== 1'b0 || retired_cnt_o !== 4'd8) begin
            errors++; $display("FAIL stall_cnt got we=%b cnt=%0d want we=0 cnt=8", reg_we_o, retired_cnt_o); end
    endtask

    task automatic test_flush();
        cyc(); put_reg(1'b1, 5'd8, 32'h88); wb_stall_i = 1'b1;
        cyc(); put_reg(1'b1, 5'd9, 32'h99);
        cyc(); put_reg(1'b1, 5'd10, 32'hAA); flush_int_i = 1'b1; #1;
        checks++; if (in_ready_o !== 1'b0 || reg_we_o !== 1'b0) begin
            errors++; $display("FAIL flush_pre got ready=%b we=%b want ready=0 we=0", in_ready_o, reg_we_o); end
        cyc(); put_reg(1'b0, 5'd0, 32'd0); flush_int_i = 1'b0; wb_stall_i = 1'b0; #1;
        checks++; if (in_ready_o !== 1'b1 || reg_we_o !== 1'b0 || instret_incr_o !== 1'b0 || retired_cnt_o !== 4'd8) begin
            errors++; $display("FAIL flush_post got ready=%b we=%b pulse=%b cnt=%0d want ready=1 we=0 pulse=0 cnt=8",
                               in_ready_o, reg_we_o, instret_incr_o, retired_cnt_o); end
        cyc(); cyc(); #1;
        checks++; if (reg_we_o !== 1'b0 || retired_cnt_o !== 4'd8) begin
            errors++; $display("FAIL flush_drain got we=%b cnt=%0d want we=0 cnt=8", reg_we_o, retired_cnt_o); end
    endtask

    task automatic test_csr_stall();
        cyc(); put_reg(1'b1, 5'd3, 32'h0); reg_we_i = 1'b0;
        csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'hDEADBEEF; wb_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); put_reg(1'b0, 5'd0, 32'd0); #1;
            checks++; if (csr_we_o !== 1'b0 || csr_waddr_o !== 12'h300 || csr_wdata_o !== 32'hDEADBEEF) begin
                errors++; $display("FAIL csr_hold%0d got we=%b a=%h d=%h want we=0 a=300 d=deadbeef",
                                   i, csr_we_o, csr_waddr_o, csr_wdata_o); end
        end
        cyc(); wb_stall_i = 1'b0; #1;
        checks++; if (csr_we_o !== 1'b1 || reg_we_o !== 1'b0) begin
            errors++; $display("FAIL csr_commit got csr_we=%b reg_we=%b want csr_we=1 reg_we=0", csr_we_o, reg_we_o); end
        cyc(); in_valid_i = 1'b1; csr_we_i = 1'b1; csr_waddr_i = 12'h000; csr_wdata_i = 32'h1234; #1;
        checks++; if (csr_we_o !== 1'b0 || retired_cnt_o !== 4'd9) begin
            errors++; $display("FAIL csr_once got we=%b cnt=%0d want we=0 cnt=9", csr_we_o, retired_cnt_o); end
        cyc(); put_reg(1'b0, 5'd0, 32'd0); #1;
        checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h000 || csr_wdata_o !== 32'h1234) begin
            errors++; $display("FAIL csr_addr0 got we=%b a=%h d=%h want we=1 a=000 d=00001234",
                               csr_we_o, csr_waddr_o, csr_wdata_o); end
    endtask

    task automatic test_wrap_and_reset();
        cyc(); rst_i = 1'b1;
        cyc(); rst_i = 1'b0; #1;
        checks++; if (retired_cnt_o !== 4'd0) begin errors++; $display("FAIL wrap_start got %0d want 0", retired_cnt_o); end
        for (int i = 0; i < 17; i++) begin
            cyc(); put_reg(1'b1, 5'd12, 32'(i));
        end
        cyc(); put_reg(1'b0, 5'd0, 32'd0);
        cyc(); #1;
        checks++; if (retired_cnt_o !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d want 1", retired_cnt_o); end
        cyc(); put_reg(1'b1, 5'd13, 32'hD0);
        cyc(); put_reg(1'b1, 5'd14, 32'hE0);
        cyc(); rst_i = 1'b1; #1;
        checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd14) begin
            errors++; $display("FAIL midrst_pre got we=%b a=%0d want we=1 a=14", reg_we_o, reg_waddr_o); end
        cyc(); rst_i = 1'b0; put_reg(1'b0, 5'd0, 32'd0); #1;
        checks++; if (reg_we_o !== 1'b0 || instret_incr_o !== 1'b0 || retired_cnt_o !== 4'd0 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL midrst_ctl got we=%b pulse=%b cnt=%0d ready=%b want we=0 pulse=0 cnt=0 ready=1",
                               reg_we_o, instret_incr_o, retired_cnt_o, in_ready_o); end
        checks++; if (reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0 || csr_waddr_o !== 12'd0 || csr_wdata_o !== 32'd0) begin
            errors++; $display("FAIL midrst_pl got ra=%0d rd=%h ca=%h cd=%h want all 0",
                               reg_waddr_o, reg_wdata_o, csr_waddr_o, csr_wdata_o); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_x0();
        test_stall();
        test_flush();
        test_csr_stall();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
